dram_req_arb: RTL and testbench

DRAM_REQ_ARB -- requirements
Module: dram_req_arb

---
 rtl/dram_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/dram_req_arb.sv | 152 +++++++++++++++
 tb/tb_dram_req_arb.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types for the DRAM request arbiter: address field layout,
// decoded request bundle and port index type.
package dram_pkg;

    localparam int BANK_W   = 3;
    localparam int ROW_W    = 7;
    localparam int COL_W    = 3;
    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = COL_LSB + COL_W;
    localparam int BANK_LSB = ROW_LSB + ROW_W;
    localparam int ADDR_W   = BANK_LSB + BANK_W;
    localparam int PORT_W   = 3;

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef struct packed {
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic              rw;
    } dram_req_t;

    function automatic dram_req_t decode_req(
        input logic [ADDR_W-1:0] addr,
        input logic              rw
    );
        dram_req_t r;
        r.bank = addr[BANK_LSB +: BANK_W];
        r.row  = addr[ROW_LSB +: ROW_W];
        r.col  = addr[COL_LSB +: COL_W];
        r.rw   = rw;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after
// last_i+1, wrapping modulo N (N a power of two).
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [N-1:0] gnt_o
);

    logic [W-1:0] idx;
    logic         found;

    // Walk the ring starting one past the previous winner.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = last_i + W'(i);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_req_arb.sv
// L2-to-DRAM request arbiter with a one-entry output register.
// Optional open-row preference: define DRAM_REQ_ARB_ROW_HIT_EN.
module dram_req_arb
    import dram_pkg::*;
#(
    parameter int L2_REQ_WIDTH    = 13,
    parameter int NUMBER_OF_PORTS = 8,
    parameter int NUMBER_OF_BANKS = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_b,
    input  logic [NUMBER_OF_PORTS-1:0]              req_valid,
    input  logic [NUMBER_OF_PORTS*L2_REQ_WIDTH-1:0] req_addr,
    input  logic [NUMBER_OF_PORTS-1:0]              req_rw,
    output logic [NUMBER_OF_PORTS-1:0]              req_ready,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [2:0]                              out_port,
    output logic [2:0]                              out_bank,
    output logic [6:0]                              out_row,
    output logic [2:0]                              out_col,
    output logic                                    out_rw
);

    localparam int PW = $clog2(NUMBER_OF_PORTS);
    localparam int BW = $clog2(NUMBER_OF_BANKS);

    dram_req_t                    req_w [NUMBER_OF_PORTS];
    dram_req_t                    sel;
    dram_req_t                    out_q, out_d;
    logic                         out_valid_q, out_valid_d;
    logic [PW-1:0]                port_q, port_d;
    logic [PW-1:0]                last_q, last_d;
    logic [PW-1:0]                gnt_idx;
    logic [NUMBER_OF_PORTS-1:0]   rr_gnt, gnt;
    logic                         can_load, port_xfer, out_xfer;

    // Split each packed port address into bank/row/col fields.
    always_comb begin
        for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
            req_w[i] = decode_req(req_addr[i*L2_REQ_WIDTH +: ADDR_W],
                                  req_rw[i]);
        end
    end

    rr_arbiter #(.N(NUMBER_OF_PORTS)) u_rr (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (rr_gnt)
    );

`ifdef DRAM_REQ_ARB_ROW_HIT_EN
    logic [ROW_W-1:0]           open_row_q [NUMBER_OF_BANKS];
    logic [NUMBER_OF_BANKS-1:0] open_vld_q;
    logic [1:0]                 hit_cnt_q;
    logic [NUMBER_OF_PORTS-1:0] hit_vec, hit_gnt;
    logic                       use_hit;

    // A port hits when its bank has a recorded open row matching its row.
    always_comb begin
        for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
            hit_vec[i] = req_valid[i]
                && open_vld_q[req_w[i].bank[BW-1:0]]
                && (open_row_q[req_w[i].bank[BW-1:0]] == req_w[i].row);
        end
    end

    rr_arbiter #(.N(NUMBER_OF_PORTS)) u_hit (
        .req_i  (hit_vec),
        .last_i (last_q),
        .gnt_o  (hit_gnt)
    );

    assign use_hit = (|hit_vec) && (hit_cnt_q != 2'd3);
    assign gnt     = use_hit ? hit_gnt : rr_gnt;

    // Track open rows as requests leave, and the run of preferred grants.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            open_vld_q <= '0;
            hit_cnt_q  <= 2'd0;
            for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
                open_row_q[b] <= '0;
            end
        end else begin
            if (out_xfer) begin
                open_row_q[out_q.bank[BW-1:0]] <= out_q.row;
                open_vld_q[out_q.bank[BW-1:0]] <= 1'b1;
            end
            if (port_xfer) begin
                hit_cnt_q <= use_hit ? hit_cnt_q + 2'd1 : 2'd0;
            end
        end
    end
`else
    assign gnt = rr_gnt;
`endif

    assign can_load  = !out_valid_q || out_ready;
    assign req_ready = gnt & {NUMBER_OF_PORTS{can_load}};
    assign port_xfer = |req_ready;
    assign out_xfer  = out_valid_q && out_ready;

    // Encode the one-hot grant and pick the winning request.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUMBER_OF_PORTS; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
        sel = req_w[gnt_idx];
    end

    // Output register next state: load on accept, drain on send.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        port_d      = port_q;
        last_d      = last_q;
        if (port_xfer) begin
            out_valid_d = 1'b1;
            out_d       = sel;
            out_d.bank  = BANK_W'(sel.bank[BW-1:0]);
            port_d      = gnt_idx;
            last_d      = gnt_idx;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            port_q      <= '0;
            last_q      <= PW'(NUMBER_OF_PORTS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            port_q      <= port_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_port  = port_q;
    assign out_bank  = out_q.bank;
    assign out_row   = out_q.row;
    assign out_col   = out_q.col;
    assign out_rw    = out_q.rw;

endmodule

// File: tb/tb_dram_req_arb.sv
// Self-checking bench for dram_req_arb: directed scenarios plus a
// randomized run against a behavioural arbitration model.
module tb_dram_req_arb;

    logic         clk;
    logic         rst_b;
    logic [7:0]   req_valid;
    logic [103:0] req_addr;
    logic [7:0]   req_rw;
    logic [7:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_port;
    logic [2:0]   out_bank;
    logic [6:0]   out_row;
    logic [2:0]   out_col;
    logic         out_rw;

    int n_checks;
    int n_fail;

    logic [12:0] v_addr [8];
    logic        v_rw   [8];

    // model state
    bit          m_ov;
    int          m_last;
    int          m_port;
    logic [2:0]  m_bank;
    logic [6:0]  m_row;
    logic [2:0]  m_col;
    logic        m_rw;
    int          m_hits;
    logic [6:0]  m_open_row [8];
    bit          m_open_vld [8];

    dram_req_arb dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_rw    (req_rw),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_port  (out_port),
        .out_bank  (out_bank),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_rw    (out_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply();
        for (int p = 0; p < 8; p++) begin
            req_addr[p*13 +: 13] = v_addr[p];
            req_rw[p]            = v_rw[p];
        end
    endtask

    task automatic do_reset();
        rst_b     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int p = 0; p < 8; p++) begin
            v_addr[p] = '0;
            v_rw[p]   = 1'b0;
        end
        apply();
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    task automatic model_reset();
        m_ov   = 0;
        m_last = 7;
        m_port = 0;
        m_hits = 0;
        for (int b = 0; b < 8; b++) begin
            m_open_vld[b] = 0;
            m_open_row[b] = '0;
        end
    endtask

    // Choose the winner: nearest valid port after the last winner,
    // restricted to open-row hits when that preference is active.
    task automatic model_pick(output int g, output bit pref);
        bit hit [8];
        bit any;
        int best_d;
        int d;
        g    = -1;
        pref = 0;
        any  = 0;
        for (int p = 0; p < 8; p++) hit[p] = 0;
        if (m_ov && !out_ready) return;
`ifdef DRAM_REQ_ARB_ROW_HIT_EN
        for (int p = 0; p < 8; p++) begin
            hit[p] = req_valid[p]
                && m_open_vld[v_addr[p][12:10]]
                && (m_open_row[v_addr[p][12:10]] == v_addr[p][9:3]);
            if (hit[p]) any = 1;
        end
        if (m_hits >= 3) any = 0;
`endif
        best_d = 8;
        for (int p = 0; p < 8; p++) begin
            if (req_valid[p] && (!any || hit[p])) begin
                d = (p - m_last + 7) % 8;
                if (d < best_d) begin
                    best_d = d;
                    g      = p;
                end
            end
        end
        pref = any;
    endtask

    task automatic model_clock(input int g, input bit pref);
        bit sent;
        sent = m_ov && out_ready;
        if (sent) begin
            m_open_row[m_bank] = m_row;
            m_open_vld[m_bank] = 1;
        end
        if (g >= 0) begin
            m_ov   = 1;
            m_port = g;
            m_bank = v_addr[g][12:10];
            m_row  = v_addr[g][9:3];
            m_col  = v_addr[g][2:0];
            m_rw   = v_rw[g];
            m_last = g;
            m_hits = pref ? m_hits + 1 : 0;
        end else if (sent) begin
            m_ov = 0;
        end
    endtask

    task automatic test_reset();
        rst_b     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        apply();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if ({out_port, out_bank, out_row, out_col, out_rw} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h expected 0",
                     {out_port, out_bank, out_row, out_col, out_rw});
        end
        n_checks++;
        if (req_ready !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ready: got %h expected 00", req_ready);
        end
        @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    task automatic test_idle();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 8'h00 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle[%0d]: got ready=%h valid=%b expected 00/0",
                         k, req_ready, out_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        do_reset();
        for (int p = 0; p < 8; p++) v_addr[p] = 13'(p * 37);
        apply();
        req_valid = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            exp = 8'(1 << (k % 8));
            n_checks++;
            if (req_ready !== exp) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %h expected %h",
                         k, req_ready, exp);
            end
            n_checks++;
            if (out_valid !== (k > 0)) begin
                n_fail++;
                $display("FAIL rr_valid[%0d]: got %b expected %b",
                         k, out_valid, (k > 0));
            end
            if (k > 0) begin
                n_checks++;
                if (out_port !== 3'(k - 1)) begin
                    n_fail++;
                    $display("FAIL rr_port[%0d]: got %0d expected %0d",
                             k, out_port, k - 1);
                end
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
    endtask

    task automatic test_hold();
        do_reset();
        v_addr[3] = 13'h19A5;
        v_rw[3]   = 1'b1;
        apply();
        req_valid = 8'h08;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 8'h08) begin
            n_fail++;
            $display("FAIL hold_first: got %h expected 08", req_ready);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 ||
                {out_port, out_bank, out_row, out_col, out_rw} !==
                {3'd3, 3'd6, 7'h34, 3'd5, 1'b1}) begin
                n_fail++;
                $display("FAIL hold_out[%0d]: got v=%b p=%0d b=%0d r=%h c=%0d w=%b expected v=1 p=3 b=6 r=34 c=5 w=1",
                         k, out_valid, out_port, out_bank, out_row,
                         out_col, out_rw);
            end
            n_checks++;
            if (req_ready !== 8'h00) begin
                n_fail++;
                $display("FAIL hold_ready[%0d]: got %h expected 00",
                         k, req_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 8'h08) begin
            n_fail++;
            $display("FAIL hold_release: got %h expected 08", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic test_pair();
        do_reset();
        out_ready = 1'b1;
        req_valid = 8'h10;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 8'h10) begin
            n_fail++;
            $display("FAIL pair_setup: got %h expected 10", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 8'h24;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 8'h20) begin
            n_fail++;
            $display("FAIL pair_first: got %h expected 20", req_ready);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 8'h04 || out_port !== 3'd5) begin
            n_fail++;
            $display("FAIL pair_second: got ready=%h port=%0d expected 04/5",
                     req_ready, out_port);
        end
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 8'h40;
        out_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_port !== 3'd6) begin
            n_fail++;
            $display("FAIL arst_loaded: got v=%b p=%0d expected 1/6",
                     out_valid, out_port);
        end
        #2 rst_b = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_port !== 3'd0) begin
            n_fail++;
            $display("FAIL arst_drop: got v=%b p=%0d expected 0/0",
                     out_valid, out_port);
        end
        @(posedge clk);
        #1 rst_b = 1'b1;
        req_valid = 8'hFF;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 8'h01 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_next: got ready=%h v=%b expected 01/0",
                     req_ready, out_valid);
        end
        @(posedge clk);
        #1 req_valid = '0;
    endtask

`ifdef DRAM_REQ_ARB_ROW_HIT_EN
    task automatic test_row_hit();
        int         exp_port [4];
        logic [7:0] exp;
        exp_port = '{4, 4, 4, 0};
        do_reset();
        v_addr[4] = {3'd1, 7'h10, 3'd0};
        v_addr[0] = {3'd1, 7'h11, 3'd0};
        apply();
        out_ready = 1'b1;
        req_valid = 8'h10;
        @(posedge clk);
        #1 req_valid = 8'h00;
        @(posedge clk);
        #1 req_valid = 8'h11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = 8'(1 << exp_port[k]);
            n_checks++;
            if (req_ready !== exp) begin
                n_fail++;
                $display("FAIL rowhit[%0d]: got %h expected %h",
                         k, req_ready, exp);
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
    endtask
`endif

    task automatic test_random();
        bit         acc [8];
        int         g;
        bit         pref;
        logic [7:0] exp;
        logic [2:0] rb;
        logic [6:0] rr;
        logic [2:0] rc;
        do_reset();
        model_reset();
        for (int p = 0; p < 8; p++) acc[p] = 1;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 8; p++) begin
                if (!(req_valid[p] && !acc[p])) begin
                    req_valid[p] = ($urandom_range(0, 99) < 45);
                    rb = 3'($urandom_range(0, 3));
                    rr = ($urandom_range(0, 1) != 0) ? 7'h10 : 7'h11;
                    rc = 3'($urandom_range(0, 7));
                    v_addr[p] = {rb, rr, rc};
                    v_rw[p]   = 1'($urandom_range(0, 1));
                end
            end
            apply();
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_pick(g, pref);
            exp = (g < 0) ? 8'h00 : 8'(1 << g);
            n_checks++;
            if (req_ready !== exp) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %h expected %h",
                         c, req_ready, exp);
            end
            n_checks++;
            if (out_valid !== m_ov) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b expected %b",
                         c, out_valid, m_ov);
            end
            if (m_ov) begin
                n_checks++;
                if ({out_port, out_bank, out_row, out_col, out_rw} !==
                    {3'(m_port), m_bank, m_row, m_col, m_rw}) begin
                    n_fail++;
                    $display("FAIL rand_fields[%0d]: got %h expected %h",
                             c, {out_port, out_bank, out_row, out_col, out_rw},
                             {3'(m_port), m_bank, m_row, m_col, m_rw});
                end
            end
            for (int p = 0; p < 8; p++) acc[p] = (g == p);
            @(posedge clk);
            model_clock(g, pref);
            #1;
        end
        req_valid = '0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_b     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_rw    = '0;
        out_ready = 1'b0;
        for (int p = 0; p < 8; p++) begin
            v_addr[p] = '0;
            v_rw[p]   = 1'b0;
        end
        test_reset();
        test_idle();
        test_round_robin();
        test_hold();
        test_pair();
        test_async_reset();
`ifdef DRAM_REQ_ARB_ROW_HIT_EN
        test_row_hit();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
